poly1305_tag_verifier: RTL and testbench
========================================

// Module: poly1305_tag_verifier
// PURPOSE
//  Receive-side (AEAD open) authenticator: recomputes the Poly1305 MAC over inbound ciphertext blocks and
//  compares it in constant time against the received tag. Pairs with the encrypt/tag core; r/s come from
//  the ChaCha20 block-0 keystream. Plaintext release logic gates on tag_ok.
// PARAMETERS
//  DIGIT_W  8  bits of r consumed per multiply cycle (1,2,4,8,16); multiply latency = 128/DIGIT_W cycles
// PORTS
//  clk          in   1    clock
//  reset        in   1    asynchronous, active-high reset
//  key_valid    in   1    load r_in/s_in/tag_in/msg_empty (accepted only when key_ready)
//  key_ready    out  1    high in IDLE
//  r_in         in   128  Poly1305 r, little-endian; clamped internally
//  s_in         in   128  Poly1305 s, little-endian
//  tag_in       in   128  received tag, byte0 at [7:0]
//  msg_empty    in   1    zero-length message: no blocks follow
//  blk_valid    in   1    ciphertext block valid
//  blk_ready    out  1    high only in ABSORB
//  blk_data     in   128  block, byte0 at [7:0]
//  blk_bytes    in   5    valid bytes 1..16; 0 or >16 treated as 16
//  blk_last     in   1    final block of message
//  abort        in   1    synchronous cancel, any state
//  busy         out  1    state != IDLE
//  result_valid out  1    one-cycle pulse; tag_ok valid with it
//  tag_ok       out  1    1 = computed tag equals tag_in; held until next key accept
// BEHAVIOUR
//  Reset: state IDLE, acc=0, r=s=tag=0, key_ready=1, blk_ready=0, busy=0, result_valid=0, tag_ok=0.
//  States IDLE->ABSORB->PREP->MUL->(ABSORB | FINAL)->COMPARE->DONE->IDLE.
//  IDLE: key_valid -> r=r_in & 0x0ffffffc0ffffffc0ffffffc0fffffff, s, tag latched, acc=0, tag_ok=0;
//   msg_empty ? FINAL : ABSORB.
//  ABSORB: blk_ready=1; on handshake: n=blk_data masked to len bytes + 2^(8*len), sum=acc+n (131b); ->PREP.
//  PREP (1 cycle): sum reduced into [0,p), p=2^130-5, by up to two conditional subtractions; start mul.
//  MUL: acc=(sum*r) mod p via sub-module; done -> blk_last latched ? FINAL : ABSORB.
//  Per-block cost: 2+128/DIGIT_W cycles handshake-to-next-blk_ready.
//  FINAL: t=(acc+s) mod 2^128 (carry discarded). COMPARE: diff = OR-reduce(t ^ tag); no early exit.
//  DONE: result_valid=1 for exactly one cycle, tag_ok=(diff==0); ->IDLE.
//  key_valid outside IDLE ignored; blk_valid outside ABSORB ignored (no ready).
//  abort: next state IDLE, acc cleared, mul cancelled, no result_valid; abort wins over any same-cycle
//   handshake or done.
//  Reset mid-operation: all state to reset values; sub-module also reset.
// CONFIGURATION
//  POLY1305_VERIFY_TAG_OUT_EN defined: extra output tag_calc[127:0] = t, valid with result_valid, held
//   until next key accept (debug only). Undefined: port absent, t never leaves the block.
// STRUCTURE
//  Package poly1305_pkg: P_130 constant, R_CLAMP mask, state enum typedef, blk-len decode function.
//  Sub-module poly1305_mulred: start/done, a<p (130b) * r (128b) mod p, MSB-first DIGIT_W-bit
//   digit-serial (acc=acc*2^DIGIT_W + a*digit, reduce each step), fixed latency 128/DIGIT_W, reset abortable.
// TESTING
//  RFC 8439 2.5.2: r=128'ha806d542fe52447f336d555778bed685, s=128'h1bf54941aff6bf4afdb20dfb8a800301,
//   "Cryptographic Forum Research Group" as 16/16/2-byte blocks, tag_in=128'ha927010caf8b2bc2c6365130c11d06a8
//   -> single result_valid pulse, tag_ok=1.
//  Same vector, tag_in bit 0 flipped -> tag_ok=0; repeat with bit 127 flipped -> identical latency, tag_ok=0.
//  msg_empty=1, s_in=tag_in=128'h0123...cdef -> tag_ok=1 after FINAL/COMPARE, blk_ready never high.
//  blk_valid held high continuously -> blk_ready low 1+128/DIGIT_W cycles between handshakes, 3 blocks consumed.
//  abort asserted mid-MUL of block 2 -> IDLE next cycle, no result_valid; immediate rerun of vector 1 -> tag_ok=1.
//  reset pulsed mid-ABSORB -> all outputs at reset values same cycle; s+acc carry case (acc+s>=2^128) wraps.

Source files
------------

// File: rtl/poly1305_pkg.sv
// Shared constants, FSM state type and block-length decode for the Poly1305 tag verifier.
package poly1305_pkg;

  localparam logic [129:0] P_130   = 130'h3_ffffffff_ffffffff_ffffffff_fffffffb;
  localparam logic [127:0] R_CLAMP = 128'h0ffffffc_0ffffffc_0ffffffc_0fffffff;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ABSORB,
    S_PREP,
    S_MUL,
    S_FINAL,
    S_COMPARE,
    S_DONE
  } state_e;

  // A zero or oversized byte count means a full 16-byte block.
  function automatic logic [4:0] blk_len(input logic [4:0] bytes);
    return ((bytes == 5'd0) || (bytes > 5'd16)) ? 5'd16 : bytes;
  endfunction

endpackage

// File: rtl/poly1305_mulred.sv
// Digit-serial (a * r) mod (2^130-5), MSB-first, fixed latency of 128/DIGIT_W busy cycles.
module poly1305_mulred
  import poly1305_pkg::*;
#(
  parameter int DIGIT_W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         cancel,
  input  logic [129:0] a,
  input  logic [127:0] r,
  output logic         done,
  output logic [129:0] y
);

  localparam int NSTEP = 128 / DIGIT_W;
  localparam int CW    = $clog2(NSTEP + 1);
  localparam int XW    = 132 + DIGIT_W;

  logic               busy_q;
  logic [CW-1:0]      cnt_q;
  logic [129:0]       a_q;
  logic [129:0]       acc_q;
  logic [127:0]       r_sh_q;

  logic [DIGIT_W-1:0] digit;
  logic [XW-1:0]      x;
  logic [DIGIT_W+1:0] hi;
  logic [130:0]       y1;
  logic [129:0]       y2;
  logic [129:0]       step;

  // Fold bits >= 2^130 back in with weight 5 (2^130 == 5 mod p); the second fold cannot overflow.
  always_comb begin
    digit = r_sh_q[127 -: DIGIT_W];
    x     = XW'({acc_q, {DIGIT_W{1'b0}}}) + XW'(a_q) * XW'(digit);
    hi    = x[XW-1:130];
    y1    = 131'(x[129:0]) + 131'(hi) * 131'd5;
    y2    = y1[129:0] + (y1[130] ? 130'd5 : 130'd0);
    step  = (y2 >= P_130) ? (y2 - P_130) : y2;
  end

  assign done = busy_q && (cnt_q == CW'(1));
  assign y    = step;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      a_q    <= '0;
      acc_q  <= '0;
      r_sh_q <= '0;
    end else if (cancel) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      acc_q  <= '0;
    end else if (start) begin
      busy_q <= 1'b1;
      cnt_q  <= CW'(NSTEP);
      a_q    <= a;
      acc_q  <= '0;
      r_sh_q <= r;
    end else if (busy_q) begin
      acc_q  <= step;
      r_sh_q <= r_sh_q << DIGIT_W;
      cnt_q  <= cnt_q - CW'(1);
      if (cnt_q == CW'(1)) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/poly1305_tag_verifier.sv
// Poly1305 receive-side tag check; POLY1305_VERIFY_TAG_OUT_EN adds a debug tag_calc output.
// state | meaning: IDLE wait key | ABSORB take block | PREP reduce sum | MUL acc=sum*r | FINAL t=acc+s | COMPARE diff | DONE pulse
module poly1305_tag_verifier
  import poly1305_pkg::*;
#(
  parameter int DIGIT_W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [127:0] r_in,
  input  logic [127:0] s_in,
  input  logic [127:0] tag_in,
  input  logic         msg_empty,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [127:0] blk_data,
  input  logic [4:0]   blk_bytes,
  input  logic         blk_last,
  input  logic         abort,
  output logic         busy,
  output logic         result_valid,
  output logic         tag_ok
`ifdef POLY1305_VERIFY_TAG_OUT_EN
  ,
  output logic [127:0] tag_calc
`endif
);

  state_e       state_q, state_d;
  logic [127:0] r_q, r_d, s_q, s_d, tag_q, tag_d, t_q, t_d;
  logic [129:0] acc_q, acc_d;
  logic [130:0] sum_q, sum_d;
  logic         last_q, last_d, tag_ok_q, tag_ok_d;

  logic [4:0]   blen;
  logic [128:0] n;
  logic [130:0] red1;
  logic [129:0] red2;
  logic         diff;
  logic         mul_start, mul_done;
  logic [129:0] mul_y;

  always_comb begin
    state_d   = state_q;
    r_d       = r_q;
    s_d       = s_q;
    tag_d     = tag_q;
    acc_d     = acc_q;
    sum_d     = sum_q;
    last_d    = last_q;
    t_d       = t_q;
    tag_ok_d  = tag_ok_q;
    mul_start = 1'b0;

    blen = blk_len(blk_bytes);
    n    = '0;
    for (int i = 0; i < 16; i++) begin
      if (5'(i) < blen) n[8*i +: 8] = blk_data[8*i +: 8];
    end
    n[{blen, 3'b000}] = 1'b1;

    red1 = (sum_q >= 131'(P_130)) ? (sum_q - 131'(P_130)) : sum_q;
    red2 = (red1 >= 131'(P_130)) ? 130'(red1 - 131'(P_130)) : red1[129:0];
    diff = |(t_q ^ tag_q);

    if (abort) begin
      state_d = S_IDLE;
      acc_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: if (key_valid) begin
          r_d      = r_in & R_CLAMP;
          s_d      = s_in;
          tag_d    = tag_in;
          acc_d    = '0;
          t_d      = '0;
          last_d   = 1'b0;
          tag_ok_d = 1'b0;
          state_d  = msg_empty ? S_FINAL : S_ABSORB;
        end
        S_ABSORB: if (blk_valid) begin
          sum_d   = 131'(acc_q) + 131'(n);
          last_d  = blk_last;
          state_d = S_PREP;
        end
        S_PREP: begin
          mul_start = 1'b1;
          state_d   = S_MUL;
        end
        S_MUL: if (mul_done) begin
          acc_d   = mul_y;
          state_d = last_q ? S_FINAL : S_ABSORB;
        end
        S_FINAL: begin
          t_d     = acc_q[127:0] + s_q;
          state_d = S_COMPARE;
        end
        S_COMPARE: begin
          tag_ok_d = ~diff;
          state_d  = S_DONE;
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      r_q      <= '0;
      s_q      <= '0;
      tag_q    <= '0;
      acc_q    <= '0;
      sum_q    <= '0;
      last_q   <= 1'b0;
      t_q      <= '0;
      tag_ok_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      r_q      <= r_d;
      s_q      <= s_d;
      tag_q    <= tag_d;
      acc_q    <= acc_d;
      sum_q    <= sum_d;
      last_q   <= last_d;
      t_q      <= t_d;
      tag_ok_q <= tag_ok_d;
    end
  end

  poly1305_mulred #(.DIGIT_W(DIGIT_W)) u_mulred (
    .clk    (clk),
    .reset  (reset),
    .start  (mul_start),
    .cancel (abort),
    .a      (red2),
    .r      (r_q),
    .done   (mul_done),
    .y      (mul_y)
  );

  assign key_ready    = (state_q == S_IDLE);
  assign blk_ready    = (state_q == S_ABSORB);
  assign busy         = (state_q != S_IDLE);
  assign result_valid = (state_q == S_DONE) && !abort;
  assign tag_ok       = tag_ok_q;

`ifdef POLY1305_VERIFY_TAG_OUT_EN
  assign tag_calc = t_q;
`endif

endmodule

// File: tb/tb_poly1305_tag_verifier.sv
// Directed + randomized checks of poly1305_tag_verifier against a big-integer Poly1305 model.
module tb_poly1305_tag_verifier;

  localparam int DW = 8;
  localparam int NS = 128 / DW;

  localparam logic [127:0] RFC_R   = 128'ha806d542fe52447f336d555778bed685;
  localparam logic [127:0] RFC_S   = 128'h1bf54941aff6bf4afdb20dfb8a800301;
  localparam logic [127:0] RFC_TAG = 128'ha927010caf8b2bc2c6365130c11d06a8;

  logic         clk, reset, key_valid, msg_empty, blk_valid, blk_last, abort;
  logic [127:0] r_in, s_in, tag_in, blk_data;
  logic [4:0]   blk_bytes;
  logic         key_ready, blk_ready, busy, result_valid, tag_ok;

  int tests, fails, cyc, t_acc;
  logic [127:0] m_data [8];
  int           m_len  [8];

  poly1305_tag_verifier #(.DIGIT_W(DW)) dut (
    .clk(clk), .reset(reset), .key_valid(key_valid), .key_ready(key_ready),
    .r_in(r_in), .s_in(s_in), .tag_in(tag_in), .msg_empty(msg_empty),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data),
    .blk_bytes(blk_bytes), .blk_last(blk_last), .abort(abort), .busy(busy),
    .result_valid(result_valid), .tag_ok(tag_ok)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Poly1305 straight from its definition, using wide integer arithmetic.
  function automatic logic [127:0] ref_tag(input logic [127:0] r, input logic [127:0] s, input int nb);
    logic [259:0] acc, nn, rr, p;
    logic [127:0] t;
    int L;
    p   = (260'd1 << 130) - 260'd5;
    rr  = 260'(r & 128'h0ffffffc0ffffffc0ffffffc0fffffff);
    acc = '0;
    for (int i = 0; i < nb; i++) begin
      L  = (m_len[i] == 0 || m_len[i] > 16) ? 16 : m_len[i];
      nn = '0;
      for (int b = 0; b < L; b++) nn[8*b +: 8] = m_data[i][8*b +: 8];
      nn  = nn + (260'd1 << (8 * L));
      acc = ((acc + nn) * rr) % p;
    end
    t = acc[127:0] + s;
    return t;
  endfunction

  task automatic load_rfc_msg();
    string msg;
    msg = "Cryptographic Forum Research Group";
    for (int k = 0; k < 8; k++) m_data[k] = '0;
    for (int i = 0; i < msg.len(); i++) m_data[i/16][8*(i%16) +: 8] = msg[i];
    m_len[0] = 16; m_len[1] = 16; m_len[2] = 2;
  endtask

  task automatic key_load(input logic [127:0] r, input logic [127:0] s, input logic [127:0] tg,
                          input logic empty);
    r_in = r; s_in = s; tag_in = tg; msg_empty = empty; key_valid = 1'b1;
    chk("key_ready_before_load", {127'd0, key_ready}, 128'd1);
    @(negedge clk);
    key_valid = 1'b0;
    t_acc = cyc;
  endtask

  task automatic send_block(input int k, input bit first, input bit last);
    int gap;
    blk_data = m_data[k]; blk_bytes = 5'(m_len[k]); blk_last = last; blk_valid = 1'b1;
    gap = 0;
    while (!blk_ready && gap < 200) begin
      @(negedge clk);
      gap++;
    end
    chk($sformatf("blk_ready_gap_%0d", k), 128'(gap), first ? 128'd0 : 128'(1 + NS));
    @(negedge clk);
  endtask

  task automatic wait_result(input int nb, input bit exp_ok, input string name);
    int w, rdy_seen;
    bit found;
    blk_valid = 1'b0;
    found = 1'b0; rdy_seen = 0;
    for (w = 0; w < 2000; w++) begin
      if (blk_ready) rdy_seen++;
      if (result_valid) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk({name, "_result_seen"}, {127'd0, found}, 128'd1);
    chk({name, "_tag_ok"}, {127'd0, tag_ok}, {127'd0, exp_ok});
    chk({name, "_latency"}, 128'(cyc - t_acc), 128'(nb * (2 + NS) + 2));
    @(negedge clk);
    chk({name, "_single_pulse"}, {127'd0, result_valid}, 128'd0);
    chk({name, "_tag_ok_held"}, {127'd0, tag_ok}, {127'd0, exp_ok});
    if (nb == 0) chk({name, "_blk_ready_never"}, 128'(rdy_seen), 128'd0);
  endtask

  task automatic run_msg(input logic [127:0] r, input logic [127:0] s, input logic [127:0] tg,
                         input int nb, input bit exp_ok, input string name);
    key_load(r, s, tg, nb == 0);
    for (int k = 0; k < nb; k++) send_block(k, k == 0, k == nb - 1);
    wait_result(nb, exp_ok, name);
  endtask

  initial begin
    logic [127:0] rr, ss, tt, rt;
    int nb, w, rv_seen;
    bit ok;
    tests = 0; fails = 0; cyc = 0;
    key_valid = 0; msg_empty = 0; blk_valid = 0; blk_last = 0; abort = 0;
    r_in = '0; s_in = '0; tag_in = '0; blk_data = '0; blk_bytes = '0;
    reset = 1'b0;
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_key_ready", {127'd0, key_ready}, 128'd1);
    chk("rst_blk_ready", {127'd0, blk_ready}, 128'd0);
    chk("rst_busy", {127'd0, busy}, 128'd0);
    chk("rst_result_valid", {127'd0, result_valid}, 128'd0);
    chk("rst_tag_ok", {127'd0, tag_ok}, 128'd0);
    reset = 1'b0;
    @(negedge clk);

    load_rfc_msg();
    run_msg(RFC_R, RFC_S, RFC_TAG, 3, 1'b1, "rfc");
    run_msg(RFC_R, RFC_S, RFC_TAG ^ 128'd1, 3, 1'b0, "rfc_bit0");
    run_msg(RFC_R, RFC_S, RFC_TAG ^ {1'b1, 127'd0}, 3, 1'b0, "rfc_bit127");
    run_msg(RFC_R, 128'h0123456789abcdef0123456789abcdef, 128'h0123456789abcdef0123456789abcdef,
            0, 1'b1, "empty");

    // Abort during the multiply of the second block.
    key_load(RFC_R, RFC_S, RFC_TAG, 1'b0);
    send_block(0, 1'b1, 1'b0);
    send_block(1, 1'b0, 1'b0);
    blk_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_busy_before", {127'd0, busy}, 128'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", {127'd0, busy}, 128'd0);
    chk("abort_key_ready", {127'd0, key_ready}, 128'd1);
    rv_seen = 0;
    for (w = 0; w < 40; w++) begin
      if (result_valid) rv_seen++;
      @(negedge clk);
    end
    chk("abort_no_result", 128'(rv_seen), 128'd0);
    run_msg(RFC_R, RFC_S, RFC_TAG, 3, 1'b1, "after_abort");

    // Reset while waiting in ABSORB for the second block.
    key_load(RFC_R, RFC_S, RFC_TAG, 1'b0);
    send_block(0, 1'b1, 1'b0);
    blk_valid = 1'b0;
    for (w = 0; w < 200 && !blk_ready; w++) @(negedge clk);
    chk("midrst_in_absorb", {127'd0, blk_ready}, 128'd1);
    reset = 1'b1;
    #1;
    chk("midrst_key_ready", {127'd0, key_ready}, 128'd1);
    chk("midrst_blk_ready", {127'd0, blk_ready}, 128'd0);
    chk("midrst_busy", {127'd0, busy}, 128'd0);
    chk("midrst_result_valid", {127'd0, result_valid}, 128'd0);
    chk("midrst_tag_ok", {127'd0, tag_ok}, 128'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_msg(RFC_R, RFC_S, RFC_TAG, 3, 1'b1, "after_reset");

    // s of all ones forces acc+s past 2^128 so the carry must be dropped.
    m_data[0] = {$urandom, $urandom, $urandom, $urandom};
    m_len[0]  = 16;
    rr = {$urandom, $urandom, $urandom, $urandom};
    ss = '1;
    run_msg(rr, ss, ref_tag(rr, ss, 1), 1, 1'b1, "carry_wrap");

    for (int it = 0; it < 8; it++) begin
      nb = $urandom_range(1, 4);
      for (int k = 0; k < nb; k++) begin
        m_data[k] = {$urandom, $urandom, $urandom, $urandom};
        m_len[k]  = $urandom_range(0, 20);
      end
      rr = {$urandom, $urandom, $urandom, $urandom};
      ss = {$urandom, $urandom, $urandom, $urandom};
      rt = ref_tag(rr, ss, nb);
      ok = 1'($urandom_range(0, 1));
      tt = ok ? rt : (rt ^ (128'd1 << $urandom_range(0, 127)));
      run_msg(rr, ss, tt, nb, ok, $sformatf("rand%0d", it));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
